debug_uart_rx_frontend: RTL and testbench

- Receive front end feeding the debug peripheral's command decoder.
- Synchronises the raw UART RX line, deserialises 8N1 frames, detects framing errors, and buffers received bytes in a small FIFO.
- Presents bytes over a valid/ready handshake so no command byte is lost while the decoder is busy, e.g. while waiting for the pipeline to flush.

---
 rtl/debug_uart_rx_frontend_pkg.sv | 28 ++
 rtl/debug_uart_rx_frontend_fifo.sv | 63 ++++++
 rtl/debug_uart_rx_frontend.sv | 160 ++++++++++++++++
 tb/tb_debug_uart_rx_frontend.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_uart_rx_frontend_pkg.sv
//------------------------------------------------------------------------------
// Module   : debug_uart_rx_frontend_pkg
// Purpose  : State encodings, frame constants and helpers for the UART RX front end.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package debug_uart_rx_frontend_pkg;

  typedef enum logic [2:0] {
    s_RX_IDLE      = 3'd0,
    s_RX_START     = 3'd1,
    s_RX_DATA      = 3'd2,
    s_RX_STOP      = 3'd3,
    s_RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int   c_DEFAULT_CLKS_PER_BIT = 868;
  localparam int   c_DATA_BITS            = 8;
  localparam logic c_STOP_LEVEL           = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debug_uart_rx_frontend_fifo.sv
//------------------------------------------------------------------------------
// Module   : rx_byte_fifo
// Purpose  : Synchronous first-word-fall-through byte FIFO with occupancy count.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rx_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_N,
  input  logic                       i_Push,
  input  logic [WIDTH-1:0]           i_Push_Data,
  input  logic                       i_Pop,
  output logic [WIDTH-1:0]           o_Pop_Data,
  output logic [$clog2(DEPTH):0]     o_Count,
  output logic                       o_Full,
  output logic                       o_Empty
);

  localparam int                c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_FULL_CNT = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_Mem [DEPTH];
  logic [c_AW-1:0]  r_Wr_Ptr;
  logic [c_AW-1:0]  r_Rd_Ptr;
  logic [c_AW:0]    r_Count;
  logic             w_Do_Push;
  logic             w_Do_Pop;

  assign o_Empty   = (r_Count == '0);
  assign o_Full    = (r_Count == c_FULL_CNT);
  assign o_Count   = r_Count;
  assign w_Do_Pop  = i_Pop && !o_Empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_Do_Push = i_Push && (!o_Full || w_Do_Pop);
  assign o_Pop_Data = o_Empty ? '0 : r_Mem[r_Rd_Ptr];

  always_ff @(posedge i_Clock) begin
    if (w_Do_Push) r_Mem[r_Wr_Ptr] <= i_Push_Data;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
    end else begin
      if (w_Do_Push) r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      if (w_Do_Pop)  r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      case ({w_Do_Push, w_Do_Pop})
        2'b10:   r_Count <= r_Count + 1'b1;
        2'b01:   r_Count <= r_Count - 1'b1;
        default: r_Count <= r_Count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/debug_uart_rx_frontend.sv
//------------------------------------------------------------------------------
// Module   : debug_uart_rx_frontend
// Purpose  : UART 8N1 receiver with framing/overflow flags feeding a byte FIFO.
//            Optional macro UART_RX_MAJORITY_VOTE_EN enables 2-of-3 sampling.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module debug_uart_rx_frontend
  import debug_uart_rx_frontend_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_N,
  input  logic                          i_Rx_Serial,
  output logic                          o_Rx_DV,
  output logic [7:0]                    o_Rx_Byte,
  input  logic                          i_Rx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Framing_Error,
  output logic                          o_Overflow,
  input  logic                          i_Clear_Errors
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int c_VOTE_DLY = 1;
`else
  localparam int c_VOTE_DLY = 0;
`endif
  // Start decision shifts by the vote delay; later bits stay a full bit apart
  localparam logic [c_CNT_W-1:0] c_MID_TAP = c_CNT_W'(CLKS_PER_BIT/2 - 1 + c_VOTE_DLY);
  localparam logic [c_CNT_W-1:0] c_BIT_TAP = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         c_LAST_BIT = 3'(c_DATA_BITS - 1);

  logic               r_Rx_Meta;
  logic               r_Rx_Sync;
  logic               w_Sample;
  rx_state_t          r_State;
  logic [c_CNT_W-1:0] r_Clk_Count;
  logic [2:0]         r_Bit_Index;
  logic [7:0]         r_Shift;
  logic               r_Framing_Error;
  logic               r_Overflow;
  logic               w_Stop_Done;
  logic               w_Push;
  logic               w_Pop;
  logic               w_Full;
  logic               w_Empty;

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      r_Rx_Meta <= 1'b1;
      r_Rx_Sync <= 1'b1;
    end else begin
      r_Rx_Meta <= i_Rx_Serial;
      r_Rx_Sync <= r_Rx_Meta;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] r_Rx_Hist;
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) r_Rx_Hist <= 2'b11;
    else            r_Rx_Hist <= {r_Rx_Hist[0], r_Rx_Sync};
  end
  assign w_Sample = majority3(r_Rx_Hist[1], r_Rx_Hist[0], r_Rx_Sync);
`else
  assign w_Sample = r_Rx_Sync;
`endif

  assign w_Stop_Done = (r_State == s_RX_STOP) && (r_Clk_Count == c_BIT_TAP);
  assign w_Push      = w_Stop_Done && (w_Sample == c_STOP_LEVEL);
  assign w_Pop       = i_Rx_Ready;

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      r_State         <= s_RX_IDLE;
      r_Clk_Count     <= '0;
      r_Bit_Index     <= '0;
      r_Shift         <= '0;
      r_Framing_Error <= 1'b0;
    end else begin
      if (w_Stop_Done && (w_Sample != c_STOP_LEVEL)) r_Framing_Error <= 1'b1;
      else if (i_Clear_Errors)                       r_Framing_Error <= 1'b0;

      case (r_State)
        s_RX_IDLE: begin
          r_Clk_Count <= '0;
          if (!r_Rx_Sync) r_State <= s_RX_START;
        end
        s_RX_START: begin
          if (r_Clk_Count == c_MID_TAP) begin
            r_Clk_Count <= '0;
            r_Bit_Index <= '0;
            r_State     <= w_Sample ? s_RX_IDLE : s_RX_DATA;
          end else begin
            r_Clk_Count <= r_Clk_Count + 1'b1;
          end
        end
        s_RX_DATA: begin
          if (r_Clk_Count == c_BIT_TAP) begin
            r_Clk_Count          <= '0;
            r_Shift[r_Bit_Index] <= w_Sample;
            if (r_Bit_Index == c_LAST_BIT) r_State <= s_RX_STOP;
            else                           r_Bit_Index <= r_Bit_Index + 1'b1;
          end else begin
            r_Clk_Count <= r_Clk_Count + 1'b1;
          end
        end
        s_RX_STOP: begin
          if (w_Stop_Done) begin
            r_Clk_Count <= '0;
            r_State     <= (w_Sample == c_STOP_LEVEL) ? s_RX_IDLE : s_RX_WAIT_IDLE;
          end else begin
            r_Clk_Count <= r_Clk_Count + 1'b1;
          end
        end
        s_RX_WAIT_IDLE: begin
          r_Clk_Count <= '0;
          if (r_Rx_Sync) r_State <= s_RX_IDLE;
        end
        default: begin
          r_Clk_Count <= '0;
          r_State     <= s_RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N)                          r_Overflow <= 1'b0;
    else if (w_Push && w_Full && !w_Pop)     r_Overflow <= 1'b1;
    else if (i_Clear_Errors)                 r_Overflow <= 1'b0;
  end

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_Clock     (i_Clock),
    .i_Reset_N   (i_Reset_N),
    .i_Push      (w_Push),
    .i_Push_Data (r_Shift),
    .i_Pop       (w_Pop),
    .o_Pop_Data  (o_Rx_Byte),
    .o_Count     (o_Fifo_Count),
    .o_Full      (w_Full),
    .o_Empty     (w_Empty)
  );

  assign o_Rx_DV         = !w_Empty;
  assign o_Framing_Error = r_Framing_Error;
  assign o_Overflow      = r_Overflow;

endmodule

`default_nettype wire

// File: tb/tb_debug_uart_rx_frontend.sv
//------------------------------------------------------------------------------
// Module   : tb_debug_uart_rx_frontend
// Purpose  : Directed self-checking bench for debug_uart_rx_frontend (CPB=8, depth 4).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_debug_uart_rx_frontend;
  import debug_uart_rx_frontend_pkg::*;

  localparam int CPB = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int STOP_TICKS = 79;
`else
  localparam int STOP_TICKS = 78;
`endif

  logic       clk;
  logic       rst_n;
  logic       line;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic [2:0] fifo_count;
  logic       fe;
  logic       ov;
  logic       clr;

  int         pass_cnt;
  int         total_cnt;
  int         dv_cycles;
  logic [7:0] rx_q[$];

  debug_uart_rx_frontend #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_Clock         (clk),
    .i_Reset_N       (rst_n),
    .i_Rx_Serial     (line),
    .o_Rx_DV         (rx_dv),
    .o_Rx_Byte       (rx_byte),
    .i_Rx_Ready      (rx_ready),
    .o_Fifo_Count    (fifo_count),
    .o_Framing_Error (fe),
    .o_Overflow      (ov),
    .i_Clear_Errors  (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_dv === 1'b1) dv_cycles++;
    if (rx_dv === 1'b1 && rx_ready === 1'b1) rx_q.push_back(rx_byte);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] q_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  task automatic send(input logic [7:0] b, input logic stop_lvl, input int spike_bit);
    line = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < CPB; k++) begin
        line = (i == spike_bit && k == 4) ? ~b[i] : b[i];
        tick();
      end
    end
    line = stop_lvl;
    repeat (CPB) tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    dv_cycles = 0;
    rst_n     = 1'b0;
    line      = 1'b1;
    rx_ready  = 1'b1;
    clr       = 1'b0;
    repeat (3) tick();
    check("reset_dv", rx_dv, 0);
    check("reset_byte", rx_byte, 0);
    check("reset_count", fifo_count, 0);
    check("reset_fe", fe, 0);
    check("reset_ov", ov, 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // single frame
    rx_q.delete();
    dv_cycles = 0;
    send(8'hA5, 1'b1, -1);
    repeat (8) tick();
    check("a5_size", rx_q.size(), 1);
    check("a5_byte", q_at(0), 8'hA5);
    check("a5_dv_cycles", dv_cycles, 1);
    check("a5_fe", fe, 0);
    check("a5_ov", ov, 0);

    // short low glitch on idle line
    line = 1'b0;
    repeat (3) tick();
    line = 1'b1;
    repeat (20) tick();
    check("glitch_size", rx_q.size(), 1);
    check("glitch_fe", fe, 0);
    check("glitch_count", fifo_count, 0);
    check("glitch_state", dut.r_State, s_RX_IDLE);

    // framing error then break, then recovery
    rx_q.delete();
    send(8'h3C, 1'b0, -1);
    repeat (40) tick();
    check("fe_set", fe, 1);
    check("fe_count", fifo_count, 0);
    check("fe_size", rx_q.size(), 0);
    line = 1'b1;
    repeat (16) tick();
    send(8'h11, 1'b1, -1);
    repeat (8) tick();
    check("recover_size", rx_q.size(), 1);
    check("recover_byte", q_at(0), 8'h11);
    check("fe_still_sticky", fe, 1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("fe_cleared", fe, 0);

    // overflow with consumer stalled
    rx_ready = 1'b0;
    rx_q.delete();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, -1);
    repeat (4) tick();
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", ov, 1);
    check("ovf_dv", rx_dv, 1);
    check("ovf_head", rx_byte, 8'h01);
    rx_ready = 1'b1;
    repeat (8) tick();
    check("drain_size", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) check("drain_byte", q_at(i), 32'(i + 1));
    check("drain_count", fifo_count, 0);
    check("drain_dv", rx_dv, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ov_cleared", ov, 0);

    // pop coincident with push into full FIFO
    rx_ready = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 4; i++) send(8'(8'h21 + i), 1'b1, -1);
    fork
      send(8'h25, 1'b1, -1);
      begin
        repeat (STOP_TICKS) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    check("coinc_count", fifo_count, 4);
    check("coinc_ov", ov, 0);
    rx_ready = 1'b1;
    repeat (8) tick();
    check("coinc_size", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) check("coinc_byte", q_at(i), 32'(8'h21 + i));

    // reset during bit 4 of a frame
    rx_q.delete();
    line = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      line = 1'b1;
      repeat (CPB) tick();
    end
    line = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_dv", rx_dv, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_state", dut.r_State, s_RX_IDLE);
    rst_n = 1'b1;
    line  = 1'b1;
    repeat (20) tick();
    check("midrst_nopush", rx_q.size(), 0);
    send(8'h7E, 1'b1, -1);
    repeat (8) tick();
    check("midrst_size", rx_q.size(), 1);
    check("midrst_byte", q_at(0), 8'h7E);

`ifdef UART_RX_MAJORITY_VOTE_EN
    rx_q.delete();
    send(8'h00, 1'b1, 2);
    repeat (8) tick();
    check("vote_size", rx_q.size(), 1);
    check("vote_byte", q_at(0), 8'h00);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
